fp_round_pack_pipe: RTL and testbench
=====================================

# fp_round_pack_pipe

Parametrised, pipelined final stage of the FPU add/sub datapath: takes the aligned, summed significand with guard/sticky bits, the larger operand's exponent, the result sign and the rounding mode. It normalises, rounds per all five RISC-V modes, detects overflow, underflow and inexact, and packs an IEEE-754 result. It replaces the single-precision combinational step-3 packer and adds format width parameters, a two-stage valid/ready pipeline and exception flags.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa width; packed result width W = 1+EXP_W+MAN_W
- CLK  input  1  clock, all state on rising edge
- RST  input  1  reset, synchronous, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  stage can accept a beat
- frm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 illegal
- exponent_max_in  input  EXP_W  biased exponent of the larger operand
- sign_in  input  1  result sign
- frac_in  input  MAN_W+3  [MAN_W+2] hidden bit, [MAN_W+1:2] mantissa, [1] guard, [0] sticky
- carry_out  input  1  adder carry above the hidden bit
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- floating_point_out  output  W  packed result
- flags_out  output  5  {NV, DZ, OF, UF, NX}; DZ is always 0

## Operation
- Stage 1 (normalise):
  - carry_out=1: shift the significand right 1, with the carry becoming the hidden bit; OR the shifted-out bit into sticky; exponent +1.
  - Hidden bit 0 with a nonzero significand: shift left by min(leading-zero count, exponent_max_in−1); decrement the exponent by the same amount.
  - If the hidden bit is still 0 after the shift, the result is subnormal and the exponent field is 0.
  - Zero significand with carry 0: result is ±0 with sign_in; no flags.
- Stage 2 (round and pack): compute round-up from guard G, sticky S, LSB L and sign.
  - RNE: G&(S|L).
  - RTZ: never rounds up.
  - RDN: round up when sign=1 and (G|S).
  - RUP: round up when sign=0 and (G|S).
  - RMM: round up when G.
- Mantissa increment carry: exponent +1 and mantissa becomes 0. A subnormal that carries into the hidden bit gets exponent field 1.
- NX = G|S.
- UF = NX and the final exponent field is 0.
- Overflow when the final exponent reaches all-ones: OF=1, NX=1.
  - Result is ±inf for RNE and RMM, for RUP when positive and for RDN when negative.
  - Result is ±max-finite for RTZ, for RUP when negative and for RDN when positive.
- Illegal frm: result is canonical qNaN (0, all-ones exponent, mantissa MSB 1), NV=1, other flags 0.
- Exponent arithmetic uses EXP_W+2 bits, so underflow and overflow are detected without wrap.

## Timing
- Latency is 2 cycles from an accepted input beat to out_valid; throughput is 1 beat/cycle.
- A beat transfers when valid&ready are high on a rising edge.
- in_ready = !s1_valid | s1_advance.
- Stage 1 advances when !s2_valid | out_ready.
- The pipeline holds 2 beats while out_ready=0; a third beat waits with in_ready=0.
- Once out_valid is asserted, the output is held stable until accepted; no drops, no reordering.
- Reset values: out_valid=0, floating_point_out=0, flags_out=0, all internal valid bits 0, in_ready=1 the cycle after RST.
- RST asserted mid-operation flushes all in-flight beats on that edge; beats presented during RST are discarded.
- Simultaneous accept at input and output moves the pipeline forward with no bubble.

## Configuration
- FPU_ROUND_FLAGS_EN defined: flag logic is built and flags_out is driven as specified.
- Undefined: flag logic is removed and flags_out is tied to 5'b0; result values are identical in both builds.

## Test plan
- RNE, exp 10, sign 0, carry 1, frac 26'b10000000000000000000101011 -> 0x05C00005, flags NX (5'b00001), out_valid exactly 2 cycles after accept.
- exp 127, sign 0, carry 0, frac 26'h2000002 (tie) -> RNE gives 0x3F800000, RMM gives 0x3F800001; both flag NX.
- exp 254, carry 1, sign 0, frac 26'h2000000 -> RTZ gives 0x7F7FFFFF and RNE gives 0x7F800000; both flag OF|NX (5'b00101).
- exp 20, sign 1, carry 0, frac 0 -> 0x80000000, flags 0; frm 3'b101 -> 0x7FC00000, flags 5'b10000.
- Hold out_ready=0 while sending 3 back-to-back beats -> in_ready falls after 2 accepts; release out_ready -> the 3 results emerge in order, one per cycle, and the held output stays stable while stalled.
- Assert RST with 2 beats in flight -> out_valid=0 on the next cycle and no stale result ever appears; rebuild without FPU_ROUND_FLAGS_EN -> flags_out stays 0 across all scenarios.

Source files
------------

// File: rtl/fp_round_pack_pipe.sv
// Two-stage normalise / round / pack back end for the FPU add/sub path.
// Define FPU_ROUND_FLAGS_EN to build the exception-flag logic; otherwise flags_out is tied to zero.
module fp_round_pack_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             frm,
  input  logic [EXP_W-1:0]       exponent_max_in,
  input  logic                   sign_in,
  input  logic [MAN_W+2:0]       frac_in,
  input  logic                   carry_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   floating_point_out,
  output logic [4:0]             flags_out
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int FW  = MAN_W + 3;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(FW + 1);

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;

  localparam logic [EW-1:0] EXP_ALL1 = {2'b00, {EXP_W{1'b1}}};

  // ---------------- stage 1: normalise ----------------
  logic [LZW-1:0] lzc;
  logic           lz_found;
  logic [EW-1:0]  exp_in_ext;
  logic [EW-1:0]  shift_lim;
  logic [EW-1:0]  shamt;
  logic [FW-1:0]  frac_shl;
  logic [FW-1:0]  norm_frac_next;
  logic [EW-1:0]  norm_exp_next;

  always_comb begin
    lzc      = LZW'(FW);
    lz_found = 1'b0;
    for (int i = FW - 1; i >= 0; i--) begin
      if (!lz_found && frac_in[i]) begin
        lzc      = LZW'(FW - 1 - i);
        lz_found = 1'b1;
      end
    end
  end

  // Left shift is capped so the exponent never drops below 1; anything
  // still lacking a hidden bit afterwards is a subnormal.
  assign exp_in_ext = EW'(exponent_max_in);
  assign shift_lim  = (exponent_max_in == '0) ? '0 : exp_in_ext - EW'(1);
  assign shamt      = (EW'(lzc) < shift_lim) ? EW'(lzc) : shift_lim;
  assign frac_shl   = frac_in << shamt;

  always_comb begin
    if (carry_out) begin
      norm_frac_next = {1'b1, frac_in[FW-1:2], |frac_in[1:0]};
      norm_exp_next  = exp_in_ext + EW'(1);
    end else begin
      norm_frac_next = frac_shl;
      norm_exp_next  = frac_shl[FW-1] ? (exp_in_ext - shamt) : '0;
    end
  end

  logic           s1_valid_reg;
  logic           s1_sign_reg;
  logic [2:0]     s1_frm_reg;
  logic [EW-1:0]  s1_exp_reg;
  logic [FW-1:0]  s1_frac_reg;
  logic           s2_valid_reg;
  logic           s1_advance;

  assign s1_advance = !s2_valid_reg || out_ready;
  assign in_ready   = !s1_valid_reg || s1_advance;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_reg <= 1'b0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
    end
  end

  always_ff @(posedge CLK) begin
    if (in_ready && in_valid) begin
      s1_sign_reg <= sign_in;
      s1_frm_reg  <= frm;
      s1_exp_reg  <= norm_exp_next;
      s1_frac_reg <= norm_frac_next;
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic             lsb_bit;
  logic             guard_bit;
  logic             sticky_bit;
  logic             hidden_bit;
  logic             round_up;
  logic             frm_illegal;
  logic [MAN_W+1:0] man_sum;
  logic [EW-1:0]    exp_rnd;
  logic             overflow;
  logic             to_inf;
  logic [W-1:0]     result_next;

  assign lsb_bit     = s1_frac_reg[2];
  assign guard_bit   = s1_frac_reg[1];
  assign sticky_bit  = s1_frac_reg[0];
  assign hidden_bit  = s1_frac_reg[FW-1];
  assign frm_illegal = (s1_frm_reg > RMM);

  always_comb begin
    round_up = 1'b0;
    case (s1_frm_reg)
      RNE:     round_up = guard_bit & (sticky_bit | lsb_bit);
      RTZ:     round_up = 1'b0;
      RDN:     round_up = s1_sign_reg & (guard_bit | sticky_bit);
      RUP:     round_up = !s1_sign_reg & (guard_bit | sticky_bit);
      RMM:     round_up = guard_bit;
      default: round_up = 1'b0;
    endcase
  end

  // A carry out of the hidden bit bumps the exponent; a subnormal rounding
  // into the hidden bit becomes the smallest normal (field 1).
  assign man_sum  = {1'b0, s1_frac_reg[FW-1:2]} + (MAN_W+2)'(round_up);
  assign exp_rnd  = s1_exp_reg + EW'(man_sum[MAN_W+1]) + EW'(!hidden_bit & man_sum[MAN_W]);
  assign overflow = (exp_rnd >= EXP_ALL1);
  assign to_inf   = (s1_frm_reg == RNE) || (s1_frm_reg == RMM) ||
                    ((s1_frm_reg == RUP) && !s1_sign_reg) ||
                    ((s1_frm_reg == RDN) && s1_sign_reg);

  always_comb begin
    result_next = {s1_sign_reg, exp_rnd[EXP_W-1:0], man_sum[MAN_W-1:0]};
    if (frm_illegal) begin
      result_next = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (overflow) begin
      if (to_inf) begin
        result_next = {s1_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else begin
        result_next = {s1_sign_reg, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end
    end
  end

  logic [W-1:0] result_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_valid_reg <= 1'b0;
      result_reg   <= '0;
    end else if (s1_advance) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        result_reg <= result_next;
      end
    end
  end

  assign out_valid          = s2_valid_reg;
  assign floating_point_out = result_reg;

`ifdef FPU_ROUND_FLAGS_EN
  logic       inexact;
  logic [4:0] flags_next;
  logic [4:0] flags_reg;

  assign inexact = guard_bit | sticky_bit;

  always_comb begin
    flags_next = {3'b000, inexact && (exp_rnd == '0), inexact};
    if (frm_illegal) begin
      flags_next = 5'b10000;
    end else if (overflow) begin
      flags_next = 5'b00101;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_reg <= '0;
    end else if (s1_advance && s1_valid_reg) begin
      flags_reg <= flags_next;
    end
  end

  assign flags_out = flags_reg;
`else
  assign flags_out = 5'b00000;
`endif

endmodule

// File: tb/tb_fp_round_pack_pipe.sv
// Scoreboarded bench for fp_round_pack_pipe (single precision); flag expectations
// follow FPU_ROUND_FLAGS_EN, all-zero when it is undefined.
module tb_fp_round_pack_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int NVEC  = 20;

`ifdef FPU_ROUND_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  frm = 3'b000;
  logic [7:0]  exponent_max_in = 8'd0;
  logic        sign_in = 1'b0;
  logic [25:0] frac_in = 26'd0;
  logic        carry_out = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] floating_point_out;
  logic [4:0]  flags_out;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fp_round_pack_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .frm(frm), .exponent_max_in(exponent_max_in), .sign_in(sign_in),
    .frac_in(frac_in), .carry_out(carry_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .floating_point_out(floating_point_out), .flags_out(flags_out)
  );

  typedef struct packed {
    logic [2:0]  m;
    logic [7:0]  e;
    logic        s;
    logic        c;
    logic [25:0] f;
    logic [31:0] r;
    logic [4:0]  fl;
  } vec_t;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  fl;
  } exp_t;

  vec_t tbl [NVEC] = '{
    '{3'b000, 8'd10,  1'b0, 1'b1, 26'b10000000000000000000101011, 32'h05C00005, 5'b00001},
    '{3'b000, 8'd127, 1'b0, 1'b0, 26'h2000002, 32'h3F800000, 5'b00001},
    '{3'b100, 8'd127, 1'b0, 1'b0, 26'h2000002, 32'h3F800001, 5'b00001},
    '{3'b001, 8'd254, 1'b0, 1'b1, 26'h2000000, 32'h7F7FFFFF, 5'b00101},
    '{3'b000, 8'd254, 1'b0, 1'b1, 26'h2000000, 32'h7F800000, 5'b00101},
    '{3'b000, 8'd20,  1'b1, 1'b0, 26'h0000000, 32'h80000000, 5'b00000},
    '{3'b101, 8'd20,  1'b1, 1'b0, 26'h0000000, 32'h7FC00000, 5'b10000},
    '{3'b011, 8'd127, 1'b0, 1'b0, 26'h2000001, 32'h3F800001, 5'b00001},
    '{3'b010, 8'd127, 1'b1, 1'b0, 26'h2000001, 32'hBF800001, 5'b00001},
    '{3'b010, 8'd127, 1'b0, 1'b0, 26'h2000001, 32'h3F800000, 5'b00001},
    '{3'b000, 8'd127, 1'b0, 1'b0, 26'h0800000, 32'h3E800000, 5'b00000},
    '{3'b000, 8'd3,   1'b0, 1'b0, 26'h0200000, 32'h00200000, 5'b00000},
    '{3'b000, 8'd1,   1'b0, 1'b0, 26'h0000003, 32'h00000001, 5'b00011},
    '{3'b000, 8'd1,   1'b0, 1'b0, 26'h1FFFFFE, 32'h00800000, 5'b00001},
    '{3'b000, 8'd127, 1'b0, 1'b0, 26'h3FFFFFE, 32'h40000000, 5'b00001},
    '{3'b011, 8'd254, 1'b1, 1'b1, 26'h2000000, 32'hFF7FFFFF, 5'b00101},
    '{3'b010, 8'd254, 1'b1, 1'b1, 26'h2000000, 32'hFF800000, 5'b00101},
    '{3'b000, 8'd254, 1'b0, 1'b0, 26'h3FFFFFE, 32'h7F800000, 5'b00101},
    '{3'b111, 8'd127, 1'b0, 1'b0, 26'h2000002, 32'h7FC00000, 5'b10000},
    '{3'b001, 8'd127, 1'b1, 1'b0, 26'h3FFFFFF, 32'hBFFFFFFF, 5'b00001}
  };

  exp_t sb_q[$];

  function automatic logic [4:0] fx(input logic [4:0] f);
    return FLAGS_ON ? f : 5'b00000;
  endfunction

  task automatic drive_vec(input int i);
    frm             = tbl[i].m;
    exponent_max_in = tbl[i].e;
    sign_in         = tbl[i].s;
    carry_out       = tbl[i].c;
    frac_in         = tbl[i].f;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    in_valid = 1'b1;
    drive_vec(0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    in_valid = 1'b0;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (floating_point_out !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", floating_point_out); end
    if (flags_out !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", flags_out); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_discard: out_valid %b expected 0", out_valid); end
    end
    @(posedge CLK); #1;
    $display("test_reset done");
  endtask

  task automatic test_latency;
    out_ready = 1'b1;
    drive_vec(0);
    in_valid = 1'b1;
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b expected 1", in_ready); end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: out_valid %b expected 0 one cycle after accept", out_valid); end
    @(posedge CLK); #1;
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: out_valid %b expected 1 two cycles after accept", out_valid); end
    if (floating_point_out !== tbl[0].r) begin errors++; $display("FAIL lat_result: got %h expected %h", floating_point_out, tbl[0].r); end
    if (flags_out !== fx(tbl[0].fl)) begin errors++; $display("FAIL lat_flags: got %b expected %b", flags_out, fx(tbl[0].fl)); end
    @(posedge CLK); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_drop: out_valid %b expected 0 after accept", out_valid); end
    $display("test_latency: result %h flags %b", floating_point_out, flags_out);
  endtask

  task automatic test_vectors;
    int got;
    int budget;
    got = 0;
    budget = 0;
    sb_q.delete();
    fork
      begin : drv
        for (int i = 0; i < NVEC; i++) begin
          bit acc;
          int tries;
          acc = 1'b0;
          tries = 0;
          drive_vec(i);
          in_valid = 1'b1;
          while (!acc && tries < 200) begin
            @(negedge CLK);
            if (in_ready) begin
              acc = 1'b1;
              sb_q.push_back({tbl[i].r, fx(tbl[i].fl)});
            end
            @(posedge CLK); #1;
            tries++;
          end
          if (!acc) begin
            checks++; errors++;
            $display("FAIL vec_accept_timeout: vector %0d never accepted", i);
          end
        end
        in_valid = 1'b0;
      end
      begin : mon
        while (got < NVEC && budget < 2000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge CLK);
          if (out_valid && out_ready) begin
            exp_t e;
            if (sb_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL vec_unexpected: result %h with empty scoreboard", floating_point_out);
            end else begin
              e = sb_q.pop_front();
              checks += 2;
              if (floating_point_out !== e.r) begin errors++; $display("FAIL vec_result[%0d]: got %h expected %h", got, floating_point_out, e.r); end
              if (flags_out !== e.fl) begin errors++; $display("FAIL vec_flags[%0d]: got %b expected %b", got, flags_out, e.fl); end
              $display("vec %0d: result %h flags %b", got, floating_point_out, flags_out);
            end
            got++;
          end
          @(posedge CLK); #1;
          budget++;
        end
        out_ready = 1'b1;
      end
    join
    checks++;
    if (got != NVEC) begin errors++; $display("FAIL vec_count: got %0d results expected %0d", got, NVEC); end
  endtask

  task automatic test_back_to_back;
    int beats [3] = '{1, 2, 7};
    exp_t e;
    sb_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_vec(beats[k]);
      in_valid = 1'b1;
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d: in_ready %b expected 1", k, in_ready); end
      sb_q.push_back({tbl[beats[k]].r, fx(tbl[beats[k]].fl)});
      @(posedge CLK); #1;
    end
    drive_vec(beats[2]);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks += 3;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: in_ready %b expected 0", in_ready); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold_valid: out_valid %b expected 1", out_valid); end
      if (floating_point_out !== sb_q[0].r) begin errors++; $display("FAIL b2b_hold_stable: got %h expected %h", floating_point_out, sb_q[0].r); end
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_release: in_ready %b expected 1", in_ready); end
        sb_q.push_back({tbl[beats[2]].r, fx(tbl[beats[2]].fl)});
      end
      e = sb_q.pop_front();
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_drain_valid%0d: out_valid %b expected 1", k, out_valid); end
      if (floating_point_out !== e.r) begin errors++; $display("FAIL b2b_drain_result%0d: got %h expected %h", k, floating_point_out, e.r); end
      if (flags_out !== e.fl) begin errors++; $display("FAIL b2b_drain_flags%0d: got %b expected %b", k, flags_out, e.fl); end
      $display("b2b %0d: result %h flags %b", k, floating_point_out, flags_out);
      @(posedge CLK); #1;
      if (k == 0) in_valid = 1'b0;
    end
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: out_valid %b expected 0", out_valid); end
    @(posedge CLK); #1;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_vec(k + 1);
      in_valid = 1'b1;
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_load%0d: in_ready %b expected 1", k, in_ready); end
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    drive_vec(3);
    in_valid = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stale: out_valid %b result %h expected no output", out_valid, floating_point_out); end
    end
    @(posedge CLK); #1;
    drive_vec(5);
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_recover_valid: got %b expected 1", out_valid); end
    if (floating_point_out !== tbl[5].r) begin errors++; $display("FAIL flush_recover_result: got %h expected %h", floating_point_out, tbl[5].r); end
    if (flags_out !== fx(tbl[5].fl)) begin errors++; $display("FAIL flush_recover_flags: got %b expected %b", flags_out, fx(tbl[5].fl)); end
    $display("test_flush: post-reset result %h flags %b", floating_point_out, flags_out);
    @(posedge CLK); #1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
